// File: rtl/add_rs_scheduler_if.sv
// Issue, CDB snoop and writeback bundle for the add/sub reservation-station scheduler.
// The master side is dispatch plus the CDB arbiter; the slave side is the scheduler.
interface add_rs_scheduler_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned TW = 3
) ();
    logic          iss_valid;
    logic          iss_ready;
    logic [3:0]    iss_func;
    logic [3:0]    iss_rd;
    logic [TW-1:0] iss_rob;
    logic [DW-1:0] iss_v1;
    logic [DW-1:0] iss_v2;
    logic [TW-1:0] iss_q1;
    logic [TW-1:0] iss_q2;
    logic          iss_r1;
    logic          iss_r2;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          wb_req;
    logic          wb_gnt;
    logic [TW-1:0] wb_tag;
    logic [3:0]    wb_rd;
    logic [DW-1:0] wb_data;

    modport master (
        output iss_valid, iss_func, iss_rd, iss_rob, iss_v1, iss_v2, iss_q1, iss_q2,
        output iss_r1, iss_r2, cdb_valid, cdb_tag, cdb_data, wb_gnt,
        input  iss_ready, wb_req, wb_tag, wb_rd, wb_data
    );

    modport slave (
        input  iss_valid, iss_func, iss_rd, iss_rob, iss_v1, iss_v2, iss_q1, iss_q2,
        input  iss_r1, iss_r2, cdb_valid, cdb_tag, cdb_data, wb_gnt,
        output iss_ready, wb_req, wb_tag, wb_rd, wb_data
    );
endinterface

// File: rtl/add_rs_scheduler.sv
// Add/sub reservation-station array with CDB snooping, oldest-ready select and a single
// shared execute unit that requests the CDB for writeback.
module add_rs_scheduler #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned LAT   = 1,
    parameter int unsigned DW    = 8,
    parameter int unsigned TW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    add_rs_scheduler_if.slave bus,
    output logic [1:0]        rs_count,
    output logic              busy
);
    localparam logic [1:0]  IDLE = 2'd0;
    localparam logic [1:0]  EXEC = 2'd1;
    localparam logic [1:0]  WB   = 2'd2;
    localparam int unsigned IW   = 2;
    localparam int unsigned CNTW = (LAT > 1) ? $clog2(LAT) : 1;

    logic [DEPTH-1:0] valid_q, r1_q, r2_q;
    logic [3:0]       func_q [DEPTH];
    logic [3:0]       rd_q   [DEPTH];
    logic [TW-1:0]    rob_q  [DEPTH];
    logic [TW-1:0]    q1_q   [DEPTH];
    logic [TW-1:0]    q2_q   [DEPTH];
    logic [DW-1:0]    v1_q   [DEPTH];
    logic [DW-1:0]    v2_q   [DEPTH];
    // Age is the rank among occupied entries: 0 is the oldest.
    logic [1:0]       age_q  [DEPTH];
    logic [2:0]       count_q;

    logic [1:0]       state_q;
    logic [CNTW-1:0]  cnt_q;
    logic [3:0]       ex_func_q, ex_rd_q;
    logic [TW-1:0]    ex_rob_q;
    logic [DW-1:0]    ex_v1_q, ex_v2_q;
    logic [TW-1:0]    wb_tag_q;
    logic [3:0]       wb_rd_q;
    logic [DW-1:0]    wb_data_q;

    logic          any_ready, any_free, iss_ready, issue, dispatch, hit1, hit2;
    logic [IW-1:0] sel_idx, free_idx;
    logic [1:0]    sel_age;
    logic [DW-1:0] result;

    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        sel_age   = '1;
        any_free  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && r1_q[i] && r2_q[i] && (!any_ready || age_q[i] < sel_age)) begin
                any_ready = 1'b1;
                sel_idx   = IW'(i);
                sel_age   = age_q[i];
            end
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign iss_ready = (count_q < 3'(DEPTH));
    assign issue     = bus.iss_valid & iss_ready & any_free;
    assign dispatch  = any_ready & ((state_q == IDLE) | ((state_q == WB) & bus.wb_gnt));
    assign hit1      = bus.cdb_valid & ~bus.iss_r1 & (bus.iss_q1 == bus.cdb_tag);
    assign hit2      = bus.cdb_valid & ~bus.iss_r2 & (bus.iss_q2 == bus.cdb_tag);

    always_comb begin
        result = '0;
        case (ex_func_q)
            4'b0000: result = ex_v1_q + ex_v2_q;
            4'b0001: result = ex_v1_q - ex_v2_q;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                func_q[i] <= '0;
                rd_q[i]   <= '0;
                rob_q[i]  <= '0;
                q1_q[i]   <= '0;
                q2_q[i]   <= '0;
                v1_q[i]   <= '0;
                v2_q[i]   <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i]) begin
                    if (bus.cdb_valid && !r1_q[i] && (q1_q[i] == bus.cdb_tag)) begin
                        v1_q[i] <= bus.cdb_data;
                        r1_q[i] <= 1'b1;
                    end
                    if (bus.cdb_valid && !r2_q[i] && (q2_q[i] == bus.cdb_tag)) begin
                        v2_q[i] <= bus.cdb_data;
                        r2_q[i] <= 1'b1;
                    end
                    if (dispatch && (age_q[i] > sel_age)) age_q[i] <= age_q[i] - 2'd1;
                end
            end
            if (dispatch) valid_q[sel_idx] <= 1'b0;
            if (issue) begin
                valid_q[free_idx] <= 1'b1;
                func_q[free_idx]  <= bus.iss_func;
                rd_q[free_idx]    <= bus.iss_rd;
                rob_q[free_idx]   <= bus.iss_rob;
                q1_q[free_idx]    <= bus.iss_q1;
                q2_q[free_idx]    <= bus.iss_q2;
                r1_q[free_idx]    <= bus.iss_r1 | hit1;
                r2_q[free_idx]    <= bus.iss_r2 | hit2;
                v1_q[free_idx]    <= hit1 ? bus.cdb_data : bus.iss_v1;
                v2_q[free_idx]    <= hit2 ? bus.cdb_data : bus.iss_v2;
                age_q[free_idx]   <= count_q[1:0] - {1'b0, dispatch};
            end
            count_q <= count_q + {2'b0, issue} - {2'b0, dispatch};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ex_func_q <= '0;
            ex_rd_q   <= '0;
            ex_rob_q  <= '0;
            ex_v1_q   <= '0;
            ex_v2_q   <= '0;
            wb_tag_q  <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (dispatch) state_q <= EXEC;
                EXEC: begin
                    if (cnt_q == CNTW'(LAT - 1)) begin
                        state_q   <= WB;
                        wb_tag_q  <= ex_rob_q;
                        wb_rd_q   <= ex_rd_q;
                        wb_data_q <= result;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                WB:      if (bus.wb_gnt) state_q <= dispatch ? EXEC : IDLE;
                default: state_q <= IDLE;
            endcase
            if (dispatch) begin
                cnt_q     <= '0;
                ex_func_q <= func_q[sel_idx];
                ex_rd_q   <= rd_q[sel_idx];
                ex_rob_q  <= rob_q[sel_idx];
                ex_v1_q   <= v1_q[sel_idx];
                ex_v2_q   <= v2_q[sel_idx];
            end
        end
    end

    assign bus.iss_ready = iss_ready;
    assign bus.wb_req    = (state_q == WB);
    assign bus.wb_tag    = wb_tag_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign rs_count      = count_q[1:0];
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_add_rs_scheduler.sv
// Directed scenarios plus a randomized run checked against a tag-indexed scoreboard
// for the add/sub reservation-station scheduler.
module tb_add_rs_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] rs_count;
    logic       busy;
    int         n_assert = 0;
    int         n_fail = 0;

    add_rs_scheduler_if bus ();

    add_rs_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rs_count (rs_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_issue(input int fn, input int rob, input int v1, input int r1,
                               input int v2, input int r2, input int q2);
        bus.iss_valid = 1'b1;
        bus.iss_func  = 4'(fn);
        bus.iss_rd    = 4'(rob + 8);
        bus.iss_rob   = 3'(rob);
        bus.iss_v1    = 8'(v1);
        bus.iss_r1    = (r1 != 0);
        bus.iss_q1    = 3'd0;
        bus.iss_v2    = 8'(v2);
        bus.iss_r2    = (r2 != 0);
        bus.iss_q2    = 3'(q2);
    endtask

    // Waits (bounded) for wb_req and checks the presented result; returns cycles waited.
    task automatic wait_wb(input string tag, input int et, input int ed, output int n);
        n = 0;
        while (!bus.wb_req && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(bus.wb_req), 1);
        check({tag, "_tag"}, 32'(bus.wb_tag), et);
        check({tag, "_rd"}, 32'(bus.wb_rd), et + 8);
        check({tag, "_data"}, 32'(bus.wb_data), ed);
    endtask

    logic [7:0] m_v1 [8];
    logic [7:0] m_v2 [8];
    logic [3:0] m_rd [8];
    int         m_fn [8];
    bit         m_w1 [8];
    bit         m_w2 [8];
    bit         m_inf [8];

    initial begin
        int n, t, fn, tg, left;
        logic [7:0] e, x1, x2;
        logic [3:0] xrd;
        bit r1, r2;

        bus.iss_valid = 1'b0;
        bus.iss_func  = '0;
        bus.iss_rd    = '0;
        bus.iss_rob   = '0;
        bus.iss_v1    = '0;
        bus.iss_v2    = '0;
        bus.iss_q1    = '0;
        bus.iss_q2    = '0;
        bus.iss_r1    = 1'b0;
        bus.iss_r2    = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = '0;
        bus.cdb_data  = '0;
        bus.wb_gnt    = 1'b1;
        for (int k = 0; k < 8; k++) m_inf[k] = 1'b0;
        tick();
        tick();
        check("rst_wb_req", 32'(bus.wb_req), 0);
        check("rst_wb_tag", 32'(bus.wb_tag), 0);
        check("rst_wb_rd", 32'(bus.wb_rd), 0);
        check("rst_wb_data", 32'(bus.wb_data), 0);
        check("rst_count", 32'(rs_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_iss_ready", 32'(bus.iss_ready), 1);
        rst_n = 1'b1;
        tick();

        // T1: single add, latency to writeback
        drive_issue(0, 2, 'h05, 1, 'h03, 1, 0);
        tick();
        bus.iss_valid = 1'b0;
        check("t1_count", 32'(rs_count), 1);
        check("t1_busy_idle", 32'(busy), 0);
        tick();
        check("t1_busy_exec", 32'(busy), 1);
        check("t1_count_freed", 32'(rs_count), 0);
        check("t1_no_req_exec", 32'(bus.wb_req), 0);
        wait_wb("t1", 2, 'h08, n);
        check("t1_latency", n, 1);
        tick();
        check("t1_req_drop", 32'(bus.wb_req), 0);
        check("t1_idle", 32'(busy), 0);

        // T2: sub with borrow, add with wrap, back-to-back
        drive_issue(1, 3, 'h02, 1, 'h05, 1, 0);
        tick();
        drive_issue(0, 4, 'hFF, 1, 'h02, 1, 0);
        tick();
        bus.iss_valid = 1'b0;
        wait_wb("t2_sub", 3, 'hFD, n);
        tick();
        wait_wb("t2_add", 4, 'h01, n);
        check("t2_b2b_gap", n, 1);
        tick();

        // T3: operand woken by a later broadcast
        drive_issue(0, 5, 'h01, 1, 'h77, 0, 4);
        tick();
        bus.iss_valid = 1'b0;
        tick();
        tick();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd4;
        bus.cdb_data  = 8'h10;
        tick();
        bus.cdb_valid = 1'b0;
        check("t3_wait_busy", 32'(busy), 0);
        tick();
        check("t3_dispatch", 32'(busy), 1);
        wait_wb("t3", 5, 'h11, n);
        tick();

        // T4: fill the station, extra issue is ignored
        for (int i = 0; i < 3; i++) begin
            drive_issue(0, i, i, 1, 'h55, 0, 6);
            tick();
        end
        check("t4_full_count", 32'(rs_count), 3);
        check("t4_not_ready", 32'(bus.iss_ready), 0);
        drive_issue(0, 3, 'h33, 1, 'h33, 1, 0);
        tick();
        bus.iss_valid = 1'b0;
        check("t4_ignored", 32'(rs_count), 3);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd6;
        bus.cdb_data  = 8'h01;
        tick();
        bus.cdb_valid = 1'b0;
        tick();
        check("t4_count_after", 32'(rs_count), 2);
        check("t4_ready_after", 32'(bus.iss_ready), 1);
        for (int i = 0; i < 3; i++) begin
            wait_wb("t4_drain", i, i + 1, n);
            tick();
        end
        tick();
        check("t4_empty", 32'(rs_count), 0);
        check("t4_no_extra", 32'(bus.wb_req), 0);

        // T5: grant stall, older woken entry beats younger ready one
        bus.wb_gnt = 1'b0;
        drive_issue(0, 1, 'h20, 1, 'h99, 0, 5);
        tick();
        drive_issue(0, 2, 'h30, 1, 'h01, 1, 0);
        tick();
        bus.iss_valid = 1'b0;
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd5;
        bus.cdb_data  = 8'h02;
        tick();
        bus.cdb_valid = 1'b0;
        drive_issue(0, 3, 'h40, 1, 'h04, 1, 0);
        tick();
        bus.iss_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_hold_req", 32'(bus.wb_req), 1);
            check("t5_hold_tag", 32'(bus.wb_tag), 2);
        end
        check("t5_hold_count", 32'(rs_count), 2);
        check("t5_hold_data", 32'(bus.wb_data), 'h31);
        bus.wb_gnt = 1'b1;
        tick();
        wait_wb("t5_older", 1, 'h22, n);
        tick();
        wait_wb("t5_younger", 3, 'h44, n);
        tick();

        // T6: reset during execute drops everything
        drive_issue(0, 1, 'h01, 1, 'h01, 1, 0);
        tick();
        drive_issue(0, 2, 'h01, 1, 'h00, 0, 6);
        tick();
        bus.iss_valid = 1'b0;
        check("t6_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_req", 32'(bus.wb_req), 0);
        check("t6_rst_count", 32'(rs_count), 0);
        check("t6_rst_ready", 32'(bus.iss_ready), 1);
        check("t6_rst_data", 32'(bus.wb_data), 0);
        tick();
        rst_n = 1'b1;
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd6;
        bus.cdb_data  = 8'h05;
        tick();
        bus.cdb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_wb", 32'(bus.wb_req), 0);
        end

        // Randomized traffic: tag 7 is an external producer that wakes waiting operands.
        for (int cyc = 0; cyc < 420; cyc++) begin
            t = -1;
            for (int k = 6; k >= 0; k--) if (!m_inf[k]) t = k;
            fn  = int'($urandom_range(0, 2));
            r1  = ($urandom_range(0, 3) != 0);
            r2  = ($urandom_range(0, 3) != 0);
            x1  = 8'($urandom);
            x2  = 8'($urandom);
            xrd = 4'($urandom);
            bus.iss_valid = (cyc < 300) && (t >= 0) && ($urandom_range(0, 2) != 0);
            bus.iss_func  = 4'(fn);
            bus.iss_rd    = xrd;
            bus.iss_rob   = 3'(t);
            bus.iss_v1    = x1;
            bus.iss_v2    = x2;
            bus.iss_r1    = r1;
            bus.iss_r2    = r2;
            bus.iss_q1    = 3'd7;
            bus.iss_q2    = 3'd7;
            bus.cdb_valid = (cyc >= 300) || ($urandom_range(0, 3) == 0);
            bus.cdb_tag   = 3'd7;
            bus.cdb_data  = 8'($urandom);
            bus.wb_gnt    = (cyc >= 300) || ($urandom_range(0, 2) != 0);
            if (bus.wb_req && bus.wb_gnt) begin
                tg = int'(bus.wb_tag);
                check("rnd_inflight", 32'(m_inf[tg]), 1);
                check("rnd_operands", 32'(m_w1[tg] | m_w2[tg]), 0);
                case (m_fn[tg])
                    0:       e = m_v1[tg] + m_v2[tg];
                    1:       e = m_v1[tg] - m_v2[tg];
                    default: e = 8'h00;
                endcase
                check("rnd_data", 32'(bus.wb_data), 32'(e));
                check("rnd_rd", 32'(bus.wb_rd), 32'(m_rd[tg]));
                m_inf[tg] = 1'b0;
            end
            if (bus.iss_valid && bus.iss_ready) begin
                m_inf[t] = 1'b1;
                m_fn[t]  = fn;
                m_rd[t]  = xrd;
                m_v1[t]  = x1;
                m_v2[t]  = x2;
                m_w1[t]  = !r1;
                m_w2[t]  = !r2;
            end
            if (bus.cdb_valid) begin
                for (int k = 0; k < 7; k++) begin
                    if (m_inf[k] && m_w1[k]) begin
                        m_v1[k] = bus.cdb_data;
                        m_w1[k] = 1'b0;
                    end
                    if (m_inf[k] && m_w2[k]) begin
                        m_v2[k] = bus.cdb_data;
                        m_w2[k] = 1'b0;
                    end
                end
            end
            tick();
        end
        bus.iss_valid = 1'b0;
        bus.cdb_valid = 1'b0;
        left = 0;
        for (int k = 0; k < 8; k++) if (m_inf[k]) left++;
        check("rnd_all_written", left, 0);
        check("rnd_final_count", 32'(rs_count), 0);
        check("rnd_final_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
